// File: rtl/barrel_shift_pkg.sv
// Shared types and constants for the multi-pass barrel shift sequencer.
package barrel_shift_pkg;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned AMT_W    = 5;
  localparam int unsigned STEP_MAX = 7;
  localparam int unsigned PASS_W   = 3;
  localparam int unsigned SEL_W    = 3;

  localparam logic MODE_LOGIC = 1'b0;
  localparam logic MODE_ROT   = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Number of passes needed to consume a full shift amount.
  function automatic logic [PASS_W-1:0] ceil_passes(input logic [AMT_W-1:0] amt);
    int unsigned tmp;
    tmp = 32'(amt);
    return PASS_W'((tmp + STEP_MAX - 1) / STEP_MAX);
  endfunction

endpackage

// File: rtl/barrel_shift_seq_stage.sv
// Single-cycle right shift / rotate by 0..7 built from 1-, 2- and 4-position mux layers.
module shift_stage
  import barrel_shift_pkg::*;
(
  input  logic [WIDTH-1:0] data,
  input  logic [SEL_W-1:0] sel,
  input  logic             mode,
  output logic [WIDTH-1:0] result
);

  logic rot;
  logic [WIDTH-1:0] l1;
  logic [WIDTH-1:0] l2;
  logic [WIDTH-1:0] l4;

  assign rot = (mode == MODE_ROT);

  always_comb begin
    l1 = data;
    if (sel[0]) l1 = rot ? {data[0], data[WIDTH-1:1]} : {1'b0, data[WIDTH-1:1]};
    l2 = l1;
    if (sel[1]) l2 = rot ? {l1[1:0], l1[WIDTH-1:2]} : {2'b00, l1[WIDTH-1:2]};
    l4 = l2;
    if (sel[2]) l4 = rot ? {l2[3:0], l2[WIDTH-1:4]} : {4'b0000, l2[WIDTH-1:4]};
  end

  assign result = l4;

endmodule

// File: rtl/barrel_shift_seq.sv
// Multi-pass sequencer: applies the 0..7 shift stage repeatedly until the
// requested amount is consumed, then presents the result on a valid/ready port.
module barrel_shift_seq
  import barrel_shift_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [WIDTH-1:0]  req_data,
  input  logic [AMT_W-1:0]  req_amt,
  input  logic              req_mode,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WIDTH-1:0]  resp_data,
  output logic [PASS_W-1:0] resp_passes,
  output logic              busy
);

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  data_r, data_nxt;
  logic [AMT_W-1:0]  rem, rem_nxt;
  logic              mode_r, mode_nxt;
  logic [PASS_W-1:0] passes, passes_nxt;
  logic [SEL_W-1:0]  step;
  logic [WIDTH-1:0]  stage_out;

  // Never step past the remaining amount, so rem cannot underflow.
  assign step = (rem > AMT_W'(STEP_MAX)) ? SEL_W'(STEP_MAX) : rem[SEL_W-1:0];

  shift_stage u_stage (
    .data   (data_r),
    .sel    (step),
    .mode   (mode_r),
    .result (stage_out)
  );

  always_comb begin
    state_nxt  = state;
    data_nxt   = data_r;
    rem_nxt    = rem;
    mode_nxt   = mode_r;
    passes_nxt = passes;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          data_nxt   = req_data;
          rem_nxt    = req_amt;
          mode_nxt   = req_mode;
          passes_nxt = '0;
          state_nxt  = (req_amt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        data_nxt   = stage_out;
        rem_nxt    = rem - AMT_W'(step);
        passes_nxt = passes + PASS_W'(1);
        if (rem <= AMT_W'(STEP_MAX)) state_nxt = DONE;
      end
      DONE: begin
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      data_r      <= '0;
      rem         <= '0;
      mode_r      <= 1'b0;
      passes      <= '0;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_data   <= '0;
      resp_passes <= '0;
      busy        <= 1'b0;
    end else begin
      state      <= state_nxt;
      data_r     <= data_nxt;
      rem        <= rem_nxt;
      mode_r     <= mode_nxt;
      passes     <= passes_nxt;
      req_ready  <= (state_nxt == IDLE);
      resp_valid <= (state_nxt == DONE);
      busy       <= (state_nxt != IDLE);
      if (state_nxt == DONE) begin
        resp_data   <= data_nxt;
        resp_passes <= passes_nxt;
      end
    end
  end

endmodule

// File: tb/tb_barrel_shift_seq.sv
// Scoreboard bench for barrel_shift_seq: directed vectors, decoupled response monitor.
module tb_barrel_shift_seq;
  import barrel_shift_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [WIDTH-1:0]  req_data = '0;
  logic [AMT_W-1:0]  req_amt = '0;
  logic              req_mode = 1'b0;
  logic              resp_valid;
  logic              resp_ready = 1'b1;
  logic [WIDTH-1:0]  resp_data;
  logic [PASS_W-1:0] resp_passes;
  logic              busy;

  barrel_shift_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_data    (req_data),
    .req_amt     (req_amt),
    .req_mode    (req_mode),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
    .resp_passes (resp_passes),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0]  data;
    logic [PASS_W-1:0] passes;
    int                lat;
  } exp_t;

  typedef struct {
    logic              mode;
    logic [WIDTH-1:0]  data;
    logic [AMT_W-1:0]  amt;
    logic [WIDTH-1:0]  ed;
    logic [PASS_W-1:0] ep;
    int                lat;
  } vec_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  bit   in_resp = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    chk_cnt++;
    if (act === want) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, want, cyc);
  endtask

  // Monitor: checks each new response against the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    int   a;
    if (rst_n !== 1'b1 || resp_valid !== 1'b1) begin
      in_resp = 1'b0;
    end else if (!in_resp) begin
      in_resp = 1'b1;
      if (exp_q.size() == 0 || acc_q.size() == 0) begin
        check("unexpected_resp", 32'(resp_data), 32'hDEAD);
      end else begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        check("resp_data", 32'(resp_data), 32'(e.data));
        check("resp_passes", 32'(resp_passes), 32'(e.passes));
        check("resp_latency", 32'(cyc - a), 32'(e.lat));
      end
    end
  end

  task automatic do_req(input vec_t v);
    exp_t e;
    bit   got;
    int   n;
    e.data = v.ed; e.passes = v.ep; e.lat = v.lat;
    exp_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b1; req_data = v.data; req_amt = v.amt; req_mode = v.mode;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      if (req_ready === 1'b1) begin
        acc_q.push_back(cyc);
        got = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    check("accept_timeout", 32'(got), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("busy_cycles", 32'(n), 32'(v.lat));
  endtask

  vec_t vecs[11] = '{
    '{MODE_LOGIC, 8'hB4, 5'd3,  8'h16, 3'd1, 2},
    '{MODE_ROT,   8'hB4, 5'd3,  8'h96, 3'd1, 2},
    '{MODE_ROT,   8'h81, 5'd9,  8'hC0, 3'd2, 3},
    '{MODE_LOGIC, 8'hFF, 5'd31, 8'h00, 3'd5, 6},
    '{MODE_LOGIC, 8'h5A, 5'd0,  8'h5A, 3'd0, 1},
    '{MODE_ROT,   8'h5A, 5'd0,  8'h5A, 3'd0, 1},
    '{MODE_ROT,   8'hB4, 5'd8,  8'hB4, 3'd2, 3},
    '{MODE_LOGIC, 8'hFF, 5'd8,  8'h00, 3'd2, 3},
    '{MODE_LOGIC, 8'h80, 5'd7,  8'h01, 3'd1, 2},
    '{MODE_ROT,   8'h01, 5'd14, 8'h04, 3'd2, 3},
    '{MODE_LOGIC, 8'hFF, 5'd15, 8'h00, 3'd3, 4}
  };

  initial begin
    exp_t e;
    bit   got;
    bit   seen;
    vec_t rv;

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_resp_data", 32'(resp_data), 32'd0);
    check("rst_resp_passes", 32'(resp_passes), 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) do_req(vecs[i]);

    // Backpressure: A is held in DONE while B waits on the request port.
    e.data = 8'h01; e.passes = 3'd1; e.lat = 2; exp_q.push_back(e);
    e.data = 8'hB4; e.passes = 3'd2; e.lat = 3; exp_q.push_back(e);
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_data = 8'h3C; req_amt = 5'd5; req_mode = MODE_LOGIC;
    check("bp_a_ready", 32'(req_ready), 32'd1);
    acc_q.push_back(cyc);
    @(negedge clk);
    req_data = 8'hB4; req_amt = 5'd8; req_mode = MODE_ROT;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (resp_valid === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    check("bp_resp_timeout", 32'(got), 32'd1);
    repeat (4) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(resp_valid), 32'd1);
      check("bp_hold_data", 32'(resp_data), 32'h01);
      check("bp_hold_passes", 32'(resp_passes), 32'd1);
      check("bp_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check("bp_idle_ready", 32'(req_ready), 32'd1);
    check("bp_idle_valid", 32'(resp_valid), 32'd0);
    check("bp_idle_busy", 32'(busy), 32'd0);
    acc_q.push_back(cyc);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 20 && busy === 1'b1; i++) @(negedge clk);
    check("bp_b_drained", 32'(busy), 32'd0);

    // Reset during the second pass of an amt=20 request.
    @(negedge clk);
    req_valid = 1'b1; req_data = 8'hFF; req_amt = 5'd20; req_mode = MODE_LOGIC;
    check("rst_op_accept", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_op_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_req_ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (resp_valid === 1'b1) seen = 1'b1;
    end
    check("abort_no_resp", 32'(seen), 32'd0);

    rv = '{MODE_ROT, 8'hB4, 5'd3, 8'h96, 3'd1, 2};
    do_req(rv);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
